spatz_issue_tracker: RTL
========================

// Module: spatz_issue_tracker
// PURPOSE
// Parametrised issue buffer between the Spatz decoder and the execution units (LSU, SLD, VFU).
// - Queues decoded spatz_req_t and stamps each with a fresh instruction ID.
// - Tracks in-flight IDs and their destination registers.
// - Stalls the queue head on a RAW/WAW hazard against in-flight writes.
// - Frees an ID on a unit completion, or at issue for CON-unit ops.
// PARAMETERS
// IdWidth    4   width of instr_id_t; NrIds = 2**IdWidth IDs in flight max
// Depth      4   request queue entries; Depth >= 1 and Depth <= NrIds
// NrRspPorts 3   completion ports (0 LSU, 1 SLD, 2 VFU)
// PORTS
// clk_i            in   1                 clock
// rst_i            in   1                 reset, asynchronous, active-high
// req_i            in   spatz_req_t       decoded request; its id field is ignored
// req_valid_i      in   1                 request valid
// req_ready_o      out  1                 request accepted when valid & ready
// issue_o          out  spatz_req_t       queue head, id field = assigned ID
// issue_valid_o    out  1                 head valid and hazard-free
// issue_ready_i    in   1                 downstream unit takes head
// rsp_valid_i      in   NrRspPorts        completion strobe per unit
// rsp_id_i         in   NrRspPorts*IdWidth completed ID per unit
// id_busy_o        out  NrIds             per-ID in-flight bitmap
// outstanding_o    out  IdWidth+1         count of busy IDs
// spurious_o       out  1                 1-cycle pulse: completion for a non-busy ID
// empty_o          out  1                 queue empty and no ID busy
// BEHAVIOUR
// - Reset values: req_ready_o=1, issue_valid_o=0, id_busy_o=0, outstanding_o=0,
//   spurious_o=0, empty_o=1; next_id=0; queue count=0.
//   Reset asserted mid-operation drops all queued and in-flight state at once.
// - Accept: req_ready_o = !full & !id_busy[next_id]. This is registered state only;
//   there is no combinational path from issue_ready_i.
//   On accept:
//   - push {req_i, id=next_id} into the queue.
//   - set id_busy[next_id].
//   - record vd/use_vd into the per-ID table.
//   - next_id += 1, wrapping modulo NrIds.
// - Latency: an entry accepted in cycle N is visible on issue_o in cycle N+1 at the
//   earliest (no fall-through).
// - Hazard: the head is blocked (issue_valid_o=0) if any busy ID other than the head's own
//   has use_vd=1 and a vd equal to one of:
//   - head vs1 with use_vs1
//   - head vs2 with use_vs2
//   - head vd with use_vd
//   Only issued IDs count; queued entries behind the head never block it.
// - Issue: pop when issue_valid_o & issue_ready_i.
//   - If head ex_unit==CON, clear its busy bit in the same cycle; CON ops get no completion.
// - Completion: for each port p with rsp_valid_i[p]:
//   - ID busy and issued: clear id_busy[rsp_id_i[p]].
//   - ID not busy, or still queued: ignore and pulse spurious_o next cycle.
//   - Several ports naming the same ID in one cycle: cleared once, no spurious flag.
// - Same cycle accept+clear: the set applies to next_id, which cannot be busy at accept,
//   so no conflict. A slot freed this cycle is usable for accept next cycle.
// - Full+pop same cycle: no accept that cycle (ready is registered), no data loss.
// - ID wrap: when next_id returns to a still-busy ID, req_ready_o=0 until that ID completes.
// - outstanding_o: popcount of id_busy, registered; updated with id_busy.
// STRUCTURE
// - spatz_pkg gains:
//   - localparam NrRspPorts
//   - instr_id_t sized from IdWidth
//   - typedef vd_rec_t {opreg_t vd; logic use_vd; logic issued;}
// - Queue: instantiate fifo_v3 (common_cells) as the one natural sub-module.
// - The busy bitmap, vd table and hazard compare live in this module.
// TESTING
// 1. Reset, then 4 back-to-back VADD (ex_unit VFU, vd=1..4) with issue_ready_i=0
//    -> IDs 0..3 assigned; req_ready_o=0 after the 4th; outstanding_o=4.
// 2. Issue VADD vd=2, then VADD vs1=2 -> second is held with issue_valid_o=0 until
//    rsp_valid_i[2]=1 with id 0; it issues the cycle after.
// 3. VCFG (CON) accepted as ID 5 -> busy bit 5 cleared on its issue handshake;
//    outstanding_o back to prior value next cycle.
// 4. rsp on port 0 for ID 9 while not busy -> spurious_o=1 for exactly 1 cycle; no state change.
// 5. Fill IDs 0..15 with IdWidth=4 and Depth=16, complete all except ID 0
//    -> 17th request stalls until ID 0 completes, then is accepted as ID 0.
// 6. Assert rst_i mid-burst with 3 queued and 2 in flight -> all outputs at reset values
//    immediately; the next request gets ID 0.

Source files
------------

// File: rtl/spatz_issue_tracker_pkg.sv
// Shared types for the Spatz issue tracker: request format, instruction IDs and
// the per-ID destination record used for hazard checks.
package spatz_issue_tracker_pkg;

    localparam int unsigned IdWidth    = 4;
    localparam int unsigned NrIds      = 2 ** IdWidth;
    localparam int unsigned NrRspPorts = 3;

    typedef logic [IdWidth-1:0] instr_id_t;
    typedef logic [4:0]         opreg_t;

    typedef enum logic [1:0] {
        CON = 2'd0,
        LSU = 2'd1,
        SLD = 2'd2,
        VFU = 2'd3
    } ex_unit_e;

    typedef enum logic [3:0] {
        VCFG     = 4'd0,
        VADD     = 4'd1,
        VSUB     = 4'd2,
        VMUL     = 4'd3,
        VLE      = 4'd4,
        VSE      = 4'd5,
        VSLIDEUP = 4'd6
    } op_e;

    typedef struct packed {
        instr_id_t id;
        ex_unit_e  ex_unit;
        op_e       op;
        opreg_t    vd;
        logic      use_vd;
        opreg_t    vs1;
        logic      use_vs1;
        opreg_t    vs2;
        logic      use_vs2;
    } spatz_req_t;

    typedef struct packed {
        opreg_t vd;
        logic   use_vd;
        logic   issued;
    } vd_rec_t;

    // True when an operand slot is in use and names the given register.
    function automatic logic reg_match(input logic use_r, input opreg_t r, input opreg_t vd);
        return use_r && (r == vd);
    endfunction

endpackage

// File: rtl/spatz_issue_tracker_if.sv
// Request, issue and completion handshakes between decoder, tracker and units.
interface spatz_issue_tracker_if;
    import spatz_issue_tracker_pkg::*;

    spatz_req_t                       req_i;
    logic                             req_valid_i;
    logic                             req_ready_o;
    spatz_req_t                       issue_o;
    logic                             issue_valid_o;
    logic                             issue_ready_i;
    logic      [NrRspPorts-1:0]       rsp_valid_i;
    instr_id_t [NrRspPorts-1:0]       rsp_id_i;

    modport master (
        output req_i, req_valid_i, issue_ready_i, rsp_valid_i, rsp_id_i,
        input  req_ready_o, issue_o, issue_valid_o
    );

    modport slave (
        input  req_i, req_valid_i, issue_ready_i, rsp_valid_i, rsp_id_i,
        output req_ready_o, issue_o, issue_valid_o
    );

endinterface

// File: rtl/spatz_issue_tracker_fifo.sv
// Registered-output FIFO for issue requests; data written in cycle N is readable
// at the head in cycle N+1 at the earliest.
module spatz_issue_tracker_fifo #(
    parameter int unsigned Depth = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam logic [AddrW-1:0] LastPtr = AddrW'(Depth - 1);

    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    dtype             mem_q [Depth];
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/spatz_issue_tracker.sv
// Issue buffer between the Spatz decoder and the LSU/SLD/VFU: stamps instruction
// IDs, tracks in-flight destinations and holds the head on RAW/WAW hazards.
module spatz_issue_tracker
    import spatz_issue_tracker_pkg::spatz_req_t;
    import spatz_issue_tracker_pkg::vd_rec_t;
    import spatz_issue_tracker_pkg::reg_match;
#(
    parameter int unsigned IdWidth    = spatz_issue_tracker_pkg::IdWidth,
    parameter int unsigned Depth      = 4,
    parameter int unsigned NrRspPorts = spatz_issue_tracker_pkg::NrRspPorts
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    spatz_issue_tracker_if.slave      bus,
    output logic [(2**IdWidth)-1:0]   id_busy_o,
    output logic [IdWidth:0]          outstanding_o,
    output logic                      spurious_o,
    output logic                      empty_o
);

    localparam int unsigned NrIds = 2 ** IdWidth;

    logic [IdWidth-1:0] next_id_q, next_id_d;
    logic [NrIds-1:0]   id_busy_q, id_busy_d;
    vd_rec_t            vd_tbl_q [NrIds];
    vd_rec_t            vd_tbl_d [NrIds];
    logic [IdWidth:0]   outstanding_q, outstanding_d;
    logic               spurious_q, spurious_d;

    logic               fifo_full, fifo_empty;
    spatz_req_t         push_req, head_req;
    logic [IdWidth-1:0] head_id;
    logic [NrIds-1:0]   conflict;
    logic [NrIds-1:0]   clr_mask, set_mask;
    logic               accept, pop;

    // Readiness comes from registered state only, never from issue_ready_i.
    assign bus.req_ready_o = ~fifo_full & ~id_busy_q[next_id_q];
    assign accept          = bus.req_valid_i & bus.req_ready_o;

    always_comb begin
        push_req    = bus.req_i;
        push_req.id = next_id_q;
    end

    spatz_issue_tracker_fifo #(
        .Depth (Depth),
        .dtype (spatz_req_t)
    ) i_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (push_req),
        .push_i  (accept),
        .data_o  (head_req),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_id = head_req.id;

    // Only issued writers can block the head; entries still queued behind it cannot.
    for (genvar gi = 0; gi < NrIds; gi++) begin : g_hazard
        assign conflict[gi] = id_busy_q[gi] && vd_tbl_q[gi].use_vd && vd_tbl_q[gi].issued
                           && (head_id != IdWidth'(gi))
                           && (reg_match(head_req.use_vs1, head_req.vs1, vd_tbl_q[gi].vd)
                            || reg_match(head_req.use_vs2, head_req.vs2, vd_tbl_q[gi].vd)
                            || reg_match(head_req.use_vd,  head_req.vd,  vd_tbl_q[gi].vd));
    end

    assign bus.issue_o       = head_req;
    assign bus.issue_valid_o = ~fifo_empty & ~|conflict;
    assign pop               = bus.issue_valid_o & bus.issue_ready_i;

    always_comb begin
        clr_mask   = '0;
        set_mask   = '0;
        spurious_d = 1'b0;
        // Several ports naming the same issued ID just set the same clear bit.
        for (int p = 0; p < NrRspPorts; p++) begin
            if (bus.rsp_valid_i[p]) begin
                if (id_busy_q[bus.rsp_id_i[p]] && vd_tbl_q[bus.rsp_id_i[p]].issued) begin
                    clr_mask[bus.rsp_id_i[p]] = 1'b1;
                end else begin
                    spurious_d = 1'b1;
                end
            end
        end
        if (pop && (head_req.ex_unit == spatz_issue_tracker_pkg::CON)) begin
            clr_mask[head_id] = 1'b1;
        end
        if (accept) begin
            set_mask[next_id_q] = 1'b1;
        end
        id_busy_d = (id_busy_q & ~clr_mask) | set_mask;
        next_id_d = accept ? next_id_q + 1'b1 : next_id_q;

        outstanding_d = '0;
        for (int i = 0; i < NrIds; i++) begin
            outstanding_d = outstanding_d + (IdWidth+1)'(id_busy_d[i]);
        end

        vd_tbl_d = vd_tbl_q;
        if (pop) begin
            vd_tbl_d[head_id].issued = 1'b1;
        end
        if (accept) begin
            vd_tbl_d[next_id_q].vd     = bus.req_i.vd;
            vd_tbl_d[next_id_q].use_vd = bus.req_i.use_vd;
            vd_tbl_d[next_id_q].issued = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            next_id_q     <= '0;
            id_busy_q     <= '0;
            outstanding_q <= '0;
            spurious_q    <= 1'b0;
            for (int i = 0; i < NrIds; i++) begin
                vd_tbl_q[i] <= '0;
            end
        end else begin
            next_id_q     <= next_id_d;
            id_busy_q     <= id_busy_d;
            outstanding_q <= outstanding_d;
            spurious_q    <= spurious_d;
            vd_tbl_q      <= vd_tbl_d;
        end
    end

    assign id_busy_o     = id_busy_q;
    assign outstanding_o = outstanding_q;
    assign spurious_o    = spurious_q;
    assign empty_o       = fifo_empty & ~|id_busy_q;

endmodule
